// File: rtl/simd_pkg.sv
// rtl/simd_pkg.sv - shared opcodes, loop fn codes, field offsets and sequencer states
package simd_pkg;

    localparam logic [3:0] OP_LOOP = 4'b0101;
    localparam logic [3:0] OP_NOP  = 4'b1111;

    localparam logic [3:0] FN_LOOP_ITER = 4'b0000;
    localparam logic [3:0] FN_LOOP_BODY = 4'b0001;

    // Loop-config immediate sits in the low half of the instruction word.
    localparam int IMM_LSB  = 0;
    localparam int IMM_BITS = 16;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        REPLAY
    } state_t;

endpackage

// File: rtl/simd_loop_buffer.sv
// rtl/simd_loop_buffer.sv - loop body register file, one write port, one asynchronous read port
module simd_loop_buffer #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/simd_loop_sequencer.sv
// rtl/simd_loop_sequencer.sv - captures a loop body while issuing it, then replays it from a local buffer
module simd_loop_sequencer
    import simd_pkg::*;
#(
    parameter int NS_ID_BITS       = 3,
    parameter int NS_INDEX_ID_BITS = 5,
    parameter int OPCODE_BITS      = 4,
    parameter int FUNCTION_BITS    = 4,
    parameter int INST_WIDTH       = 32,
    parameter int MAX_BODY         = 16,
    parameter int ITER_WIDTH       = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [INST_WIDTH-1:0]       inst_in,
    input  logic                        inst_in_valid,
    output logic                        inst_in_ready,
    output logic [OPCODE_BITS-1:0]      opcode,
    output logic [FUNCTION_BITS-1:0]    fn,
    output logic [NS_ID_BITS-1:0]       dest_ns_id,
    output logic [NS_INDEX_ID_BITS-1:0] dest_ns_index_id,
    output logic [NS_ID_BITS-1:0]       src1_ns_id,
    output logic [NS_INDEX_ID_BITS-1:0] src1_ns_index_id,
    output logic [NS_ID_BITS-1:0]       src2_ns_id,
    output logic [NS_INDEX_ID_BITS-1:0] src2_ns_index_id,
    output logic                        inst_out_valid,
    output logic                        in_single_loop,
    output logic                        loop_busy,
    output logic                        loop_done,
    output logic                        loop_err
);

    localparam int AW       = $clog2(MAX_BODY);
    localparam int SLOT     = NS_ID_BITS + NS_INDEX_ID_BITS;
    localparam int OPC_LSB  = INST_WIDTH - OPCODE_BITS;
    localparam int FN_LSB   = OPC_LSB - FUNCTION_BITS;
    localparam logic [INST_WIDTH-1:0] NOP_INST =
        {OPCODE_BITS'(OP_NOP), FUNCTION_BITS'(OP_NOP), {(INST_WIDTH-OPCODE_BITS-FUNCTION_BITS){1'b0}}};

    state_t                 state;
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [ITER_WIDTH-1:0]  iter_cnt;
    logic [ITER_WIDTH-1:0]  body_len;
    logic [ITER_WIDTH-1:0]  remaining;
    logic [INST_WIDTH-1:0]  out_inst;
    logic [INST_WIDTH-1:0]  rd_data;

    logic                     accept;
    logic [OPCODE_BITS-1:0]   in_opc;
    logic [FUNCTION_BITS-1:0] in_fn;
    logic [ITER_WIDTH-1:0]    imm;
    logic                     last_wr;
    logic                     last_rd;

    assign inst_in_ready = (state != REPLAY);
    assign accept        = inst_in_valid && inst_in_ready;
    assign in_opc        = inst_in[OPC_LSB +: OPCODE_BITS];
    assign in_fn         = inst_in[FN_LSB +: FUNCTION_BITS];
    assign imm           = inst_in[IMM_LSB +: IMM_BITS];
    assign last_wr       = (ITER_WIDTH'(wr_ptr) == body_len - 1'b1);
    assign last_rd       = (ITER_WIDTH'(rd_ptr) == body_len - 1'b1);

    simd_loop_buffer #(
        .DEPTH (MAX_BODY),
        .WIDTH (INST_WIDTH),
        .AW    (AW)
    ) u_buf (
        .clk   (clk),
        .we    ((state == CAPTURE) && accept),
        .waddr (wr_ptr),
        .wdata (inst_in),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            iter_cnt       <= '0;
            body_len       <= '0;
            remaining      <= '0;
            out_inst       <= NOP_INST;
            inst_out_valid <= 1'b0;
            in_single_loop <= 1'b0;
            loop_done      <= 1'b0;
            loop_err       <= 1'b0;
        end else begin
            out_inst       <= NOP_INST;
            inst_out_valid <= 1'b0;
            in_single_loop <= 1'b0;
            loop_done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (in_opc == OPCODE_BITS'(OP_LOOP)) begin
                            if (in_fn == FUNCTION_BITS'(FN_LOOP_ITER)) begin
                                iter_cnt <= imm;
                            end else if (in_fn == FUNCTION_BITS'(FN_LOOP_BODY)) begin
                                body_len <= imm;
                                // Oversized bodies are dropped; zero-length ones are a no-op.
                                if (imm > ITER_WIDTH'(MAX_BODY)) begin
                                    loop_err <= 1'b1;
                                end else if (imm != '0) begin
                                    state  <= CAPTURE;
                                    wr_ptr <= '0;
                                end
                            end
                        end else begin
                            out_inst       <= inst_in;
                            inst_out_valid <= 1'b1;
                        end
                    end
                end
                CAPTURE: begin
                    if (accept) begin
                        out_inst       <= inst_in;
                        inst_out_valid <= 1'b1;
                        if (last_wr) begin
                            wr_ptr <= '0;
                            if (iter_cnt >= ITER_WIDTH'(2)) begin
                                state     <= REPLAY;
                                rd_ptr    <= '0;
                                remaining <= iter_cnt - 1'b1;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                    end
                end
                REPLAY: begin
                    out_inst       <= rd_data;
                    inst_out_valid <= 1'b1;
                    in_single_loop <= 1'b1;
                    if (last_rd) begin
                        rd_ptr    <= '0;
                        remaining <= remaining - 1'b1;
                        if (remaining == ITER_WIDTH'(1)) begin
                            loop_done <= 1'b1;
                            state     <= IDLE;
                        end
                    end else begin
                        rd_ptr <= rd_ptr + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // loop_done is emitted after the state has already returned to IDLE.
    assign loop_busy = (state != IDLE) || loop_done;

    assign opcode           = out_inst[OPC_LSB +: OPCODE_BITS];
    assign fn               = out_inst[FN_LSB +: FUNCTION_BITS];
    assign dest_ns_id       = out_inst[2*SLOT + NS_INDEX_ID_BITS +: NS_ID_BITS];
    assign dest_ns_index_id = out_inst[2*SLOT +: NS_INDEX_ID_BITS];
    assign src1_ns_id       = out_inst[SLOT + NS_INDEX_ID_BITS +: NS_ID_BITS];
    assign src1_ns_index_id = out_inst[SLOT +: NS_INDEX_ID_BITS];
    assign src2_ns_id       = out_inst[NS_INDEX_ID_BITS +: NS_ID_BITS];
    assign src2_ns_index_id = out_inst[0 +: NS_INDEX_ID_BITS];

endmodule

// File: tb/tb_simd_loop_sequencer.sv
// tb/tb_simd_loop_sequencer.sv - directed self-checking bench for simd_loop_sequencer
module tb_simd_loop_sequencer;

    logic        clk;
    logic        reset;
    logic [31:0] inst_in;
    logic        inst_in_valid;
    logic        inst_in_ready;
    logic [3:0]  opcode;
    logic [3:0]  fn;
    logic [2:0]  dest_ns_id;
    logic [4:0]  dest_ns_index_id;
    logic [2:0]  src1_ns_id;
    logic [4:0]  src1_ns_index_id;
    logic [2:0]  src2_ns_id;
    logic [4:0]  src2_ns_index_id;
    logic        inst_out_valid;
    logic        in_single_loop;
    logic        loop_busy;
    logic        loop_done;
    logic        loop_err;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [31:0] NOP = 32'hFF00_0000;
    localparam logic [31:0] A   = 32'h1234_5678;
    localparam logic [31:0] B   = 32'h2A5B_3C4D;
    localparam logic [31:0] C   = 32'h3000_00FF;
    localparam logic [31:0] D   = 32'h6111_2222;
    localparam logic [31:0] E   = 32'h7333_4444;
    localparam logic [31:0] F   = 32'h8555_6666;
    localparam logic [31:0] G   = 32'h9ABC_DEF0;
    localparam logic [31:0] H   = 32'h0F0E_0D0C;

    simd_loop_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .inst_in          (inst_in),
        .inst_in_valid    (inst_in_valid),
        .inst_in_ready    (inst_in_ready),
        .opcode           (opcode),
        .fn               (fn),
        .dest_ns_id       (dest_ns_id),
        .dest_ns_index_id (dest_ns_index_id),
        .src1_ns_id       (src1_ns_id),
        .src1_ns_index_id (src1_ns_index_id),
        .src2_ns_id       (src2_ns_id),
        .src2_ns_index_id (src2_ns_index_id),
        .inst_out_valid   (inst_out_valid),
        .in_single_loop   (in_single_loop),
        .loop_busy        (loop_busy),
        .loop_done        (loop_done),
        .loop_err         (loop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] out_word;
    logic [5:0]  flags;
    assign out_word = {opcode, fn, dest_ns_id, dest_ns_index_id,
                       src1_ns_id, src1_ns_index_id, src2_ns_id, src2_ns_index_id};
    // {valid, single, busy, done, err, ready}
    assign flags = {inst_out_valid, in_single_loop, loop_busy, loop_done, loop_err, inst_in_ready};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_o(input string tag, input logic [31:0] exp_word, input logic [5:0] exp_flags);
        check({tag, ".word"}, out_word, exp_word);
        check({tag, ".flags"}, {26'd0, flags}, {26'd0, exp_flags});
    endtask

    task automatic drive(input logic v, input logic [31:0] d);
        inst_in_valid = v;
        inst_in       = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset         = 1'b0;
        inst_in_valid = 1'b0;
        inst_in       = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        expect_o("reset", NOP, 6'b000001);
        reset = 1'b1;

        // Pass-through in IDLE
        drive(1'b1, A);               expect_o("pass_a", A, 6'b100001);
        drive(1'b1, B);               expect_o("pass_b", B, 6'b100001);
        drive(1'b1, C);               expect_o("pass_c", C, 6'b100001);
        drive(1'b0, 32'd0);           expect_o("pass_idle", NOP, 6'b000001);

        // iter=3, body=2
        drive(1'b1, 32'h5000_0003);   expect_o("l1_iter", NOP, 6'b000001);
        drive(1'b1, 32'h5100_0002);   expect_o("l1_body", NOP, 6'b001001);
        drive(1'b1, A);               expect_o("l1_cap_a", A, 6'b101001);
        drive(1'b1, B);               expect_o("l1_cap_b", B, 6'b101000);
        drive(1'b0, 32'd0);           expect_o("l1_rep_a0", A, 6'b111000);
        drive(1'b0, 32'd0);           expect_o("l1_rep_b0", B, 6'b111000);
        drive(1'b0, 32'd0);           expect_o("l1_rep_a1", A, 6'b111000);
        drive(1'b0, 32'd0);           expect_o("l1_rep_b1", B, 6'b111101);
        drive(1'b0, 32'd0);           expect_o("l1_after", NOP, 6'b000001);

        // iter=1, body=4 with an embedded loop opcode treated as data
        drive(1'b1, 32'h5000_0001);   expect_o("l2_iter", NOP, 6'b000001);
        drive(1'b1, 32'h5100_0004);   expect_o("l2_body", NOP, 6'b001001);
        drive(1'b1, C);               expect_o("l2_cap0", C, 6'b101001);
        drive(1'b1, 32'h5000_0009);   expect_o("l2_cap1", 32'h5000_0009, 6'b101001);
        drive(1'b1, D);               expect_o("l2_cap2", D, 6'b101001);
        drive(1'b1, E);               expect_o("l2_cap3", E, 6'b100001);
        drive(1'b0, 32'd0);           expect_o("l2_after", NOP, 6'b000001);

        // Oversized body
        drive(1'b1, 32'h5100_0011);   expect_o("err_body", NOP, 6'b000011);
        drive(1'b1, A);               expect_o("err_pass", A, 6'b100011);
        drive(1'b0, 32'd0);           expect_o("err_sticky", NOP, 6'b000011);

        // iter=2, body=3 with input gaps during capture
        drive(1'b1, 32'h5000_0002);   expect_o("l3_iter", NOP, 6'b000011);
        drive(1'b1, 32'h5100_0003);   expect_o("l3_body", NOP, 6'b001011);
        drive(1'b1, D);               expect_o("l3_cap_d", D, 6'b101011);
        drive(1'b0, 32'd0);           expect_o("l3_gap0", NOP, 6'b001011);
        drive(1'b1, E);               expect_o("l3_cap_e", E, 6'b101011);
        drive(1'b0, 32'd0);           expect_o("l3_gap1", NOP, 6'b001011);
        drive(1'b1, F);               expect_o("l3_cap_f", F, 6'b101010);
        drive(1'b0, 32'd0);           expect_o("l3_rep_d", D, 6'b111010);
        drive(1'b0, 32'd0);           expect_o("l3_rep_e", E, 6'b111010);
        drive(1'b0, 32'd0);           expect_o("l3_rep_f", F, 6'b111111);
        drive(1'b0, 32'd0);           expect_o("l3_after", NOP, 6'b000011);

        // iter=4, body=2, reset during the second replay cycle
        drive(1'b1, 32'h5000_0004);   expect_o("l4_iter", NOP, 6'b000011);
        drive(1'b1, 32'h5100_0002);   expect_o("l4_body", NOP, 6'b001011);
        drive(1'b1, G);               expect_o("l4_cap_g", G, 6'b101011);
        drive(1'b1, H);               expect_o("l4_cap_h", H, 6'b101010);
        drive(1'b0, 32'd0);           expect_o("l4_rep_g", G, 6'b111010);
        drive(1'b0, 32'd0);           expect_o("l4_rep_h", H, 6'b111010);
        #1;
        reset = 1'b0;
        #1;
        expect_o("l4_async_rst", NOP, 6'b000001);
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(1'b1, A);               expect_o("l4_post_pass", A, 6'b100001);
        drive(1'b0, 32'd0);           expect_o("l4_no_replay", NOP, 6'b000001);
        drive(1'b0, 32'd0);           expect_o("l4_quiet", NOP, 6'b000001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
